tiny_rv_mprf_sb: RTL and testbench

//  Parametrised multi-port register file with integrated scoreboard; successor to the

---
 rtl/tiny_rv_mprf_sb.sv | 108 ++++++++++
 tb/tb_tiny_rv_mprf_sb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tiny_rv_mprf_sb.sv
// tiny_rv_mprf_sb: multi-port register file with a per-register busy scoreboard.
// Reads are combinational (with optional same-cycle write forwarding), writes land
// at the rising edge, and busy bits track in-flight producers for RAW/WAW detection.
module tiny_rv_mprf_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NRD*AW-1:0]    i_rd_addr,
  output logic [NRD*XLEN-1:0]  o_rd_data,
  output logic [NRD-1:0]       o_rd_busy,
  output logic                 o_raw_hazard,
  input  logic [NWR-1:0]       i_wr_en,
  input  logic [NWR*AW-1:0]    i_wr_addr,
  input  logic [NWR*XLEN-1:0]  i_wr_data,
  input  logic                 i_issue_en,
  input  logic [AW-1:0]        i_issue_rd,
  output logic                 o_issue_ready,
  input  logic                 i_flush,
  output logic [AW:0]          o_busy_cnt
);

  localparam logic BYP = (BYPASS != 0);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] clr;
  logic [AW:0]      busy_cnt_q;
  logic [AW:0]      cnt_d;

  // Registers being written this cycle: their pending producer completes now.
  always_comb begin
    clr = '0;
    for (int j = 0; j < NWR; j++) begin
      if (i_wr_en[j]) clr[i_wr_addr[j*AW +: AW]] = 1'b1;
    end
    clr[0] = 1'b0;
  end

  // Issue gating, next busy vector and its popcount; flush overrides everything.
  always_comb begin
    logic pend;
    pend          = busy_q[i_issue_rd] & ~(BYP & clr[i_issue_rd]);
    o_issue_ready = (i_issue_rd == '0) | ~pend;
    if (i_flush) begin
      busy_d = '0;
    end else begin
      busy_d = busy_q & ~clr;
      if (i_issue_en && o_issue_ready && (i_issue_rd != '0)) busy_d[i_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int r = 0; r < NREGS; r++) cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
  end

  // Combinational read ports; the highest-index matching write port forwards its data.
  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    o_rd_data = '0;
    o_rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      a = i_rd_addr[k*AW +: AW];
      d = mem_q[a];
      if (BYP) begin
        for (int j = 0; j < NWR; j++) begin
          if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == a)) d = i_wr_data[j*XLEN +: XLEN];
        end
      end
      if (a == '0) d = '0;
      o_rd_data[k*XLEN +: XLEN] = d;
      o_rd_busy[k] = (a != '0) & busy_q[a] & ~(BYP & clr[a]);
    end
  end

  assign o_raw_hazard = |o_rd_busy;
  assign o_busy_cnt   = busy_cnt_q;

  // Storage update; later write ports override earlier ones on the same address.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] != '0))
          mem_q[i_wr_addr[j*AW +: AW]] <= i_wr_data[j*XLEN +: XLEN];
      end
    end
  end

  // Scoreboard state: busy bits and their registered count move on the same edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tiny_rv_mprf_sb.sv
// Scoreboard bench for tiny_rv_mprf_sb (two write ports, forwarding enabled).
module tb_tiny_rv_mprf_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                raw_hazard;
  logic [NWR-1:0]      wr_en = '0;
  logic [NWR*AW-1:0]   wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic                issue_en = 1'b0;
  logic [AW-1:0]       issue_rd = '0;
  logic                issue_ready;
  logic                flush = 1'b0;
  logic [AW:0]         busy_cnt;

  tiny_rv_mprf_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_rd_busy(rd_busy), .o_raw_hazard(raw_hazard), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_issue_en(issue_en), .i_issue_rd(issue_rd),
    .o_issue_ready(issue_ready), .i_flush(flush), .o_busy_cnt(busy_cnt));

  always #5 clk = ~clk;

  typedef struct {
    bit                         rst;
    logic [NRD-1:0][AW-1:0]     ra;
    logic [NWR-1:0]             we;
    logic [NWR-1:0][AW-1:0]     wa;
    logic [NWR-1:0][XLEN-1:0]   wd;
    bit                         ie;
    logic [AW-1:0]              ird;
    bit                         fl;
  } stim_t;

  typedef struct {
    logic [NRD-1:0][XLEN-1:0] d;
    logic [NRD-1:0]           b;
    logic                     raw;
    logic                     rdy;
    logic [AW:0]              cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   drv_done = 0;

  // Reference model: architectural contents and set of registers awaiting a producer.
  logic [XLEN-1:0] m_reg [NREGS];
  bit              m_busy[NREGS];

  function automatic void model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 0;
    end
  endfunction

  function automatic bit written(stim_t s, int r);
    for (int j = 0; j < NWR; j++) if (s.we[j] && int'(s.wa[j]) == r) return 1;
    return 0;
  endfunction

  function automatic exp_t predict(stim_t s);
    exp_t e;
    int   a;
    e.cnt = '0;
    for (int r = 0; r < NREGS; r++) if (m_busy[r]) e.cnt = e.cnt + 1'b1;
    for (int k = 0; k < NRD; k++) begin
      a = int'(s.ra[k]);
      e.d[k] = m_reg[a];
      for (int j = 0; j < NWR; j++) if (s.we[j] && int'(s.wa[j]) == a) e.d[k] = s.wd[j];
      if (a == 0) e.d[k] = '0;
      e.b[k] = (a != 0) && m_busy[a] && !written(s, a);
    end
    e.raw = |e.b;
    e.rdy = (s.ird == 0) || !(m_busy[s.ird] && !written(s, int'(s.ird)));
    return e;
  endfunction

  function automatic void model_step(stim_t s, logic rdy);
    for (int j = 0; j < NWR; j++) if (s.we[j] && s.wa[j] != 0) m_reg[s.wa[j]] = s.wd[j];
    if (s.fl) begin
      for (int r = 0; r < NREGS; r++) m_busy[r] = 0;
    end else begin
      for (int r = 0; r < NREGS; r++) if (written(s, r)) m_busy[r] = 0;
      if (s.ie && rdy && s.ird != 0) m_busy[s.ird] = 1;
    end
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk); #1;
    rst_n    = !s.rst;
    rd_addr  = s.ra;
    wr_en    = s.we;
    wr_addr  = s.wa;
    wr_data  = s.wd;
    issue_en = s.ie;
    issue_rd = s.ird;
    flush    = s.fl;
    if (s.rst) model_reset();
    e = predict(s);
    exp_q.push_back(e);
    if (!s.rst) model_step(s, e.rdy);
  endtask

  task automatic op(input bit rst, input int ra0, input int ra1,
                    input bit we0, input int wa0, input logic [31:0] wd0,
                    input bit we1, input int wa1, input logic [31:0] wd1,
                    input bit ie, input int ird, input bit fl);
    stim_t s;
    s.rst = rst;
    s.ra[0] = AW'(ra0); s.ra[1] = AW'(ra1);
    s.we[0] = we0; s.wa[0] = AW'(wa0); s.wd[0] = wd0;
    s.we[1] = we1; s.wa[1] = AW'(wa1); s.wd[1] = wd1;
    s.ie = ie; s.ird = AW'(ird); s.fl = fl;
    apply(s);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s t=%0t actual=0x%08h required=0x%08h", name, $time, act, req);
  endtask

  // Monitor: every presented cycle is compared against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < NRD; k++) begin
          check($sformatf("rd_data[%0d]", k), rd_data[k*XLEN +: XLEN], e.d[k]);
          check($sformatf("rd_busy[%0d]", k), 32'(rd_busy[k]), 32'(e.b[k]));
        end
        check("raw_hazard", 32'(raw_hazard), 32'(e.raw));
        check("issue_ready", 32'(issue_ready), 32'(e.rdy));
        check("busy_cnt", 32'(busy_cnt), 32'(e.cnt));
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic with occasional reset/flush.
  initial begin
    model_reset();
    //  rst ra0 ra1 we0 wa0 wd0           we1 wa1 wd1   ie ird fl
    op(1, 0, 0,  0, 0, 0,              0, 0, 0,      0, 0, 0);
    op(0, 5, 5,  1, 5, 32'h1234,       0, 0, 0,      0, 0, 0);
    op(0, 5, 0,  0, 0, 0,              0, 0, 0,      1, 5, 0);
    op(1, 5, 5,  0, 0, 0,              0, 0, 0,      0, 0, 0);
    op(0, 5, 5,  0, 0, 0,              0, 0, 0,      0, 0, 0);
    op(0, 0, 0,  1, 0, 32'hDEADBEEF,   0, 0, 0,      1, 0, 0);
    op(0, 0, 0,  0, 0, 0,              0, 0, 0,      1, 0, 0);
    op(0, 0, 0,  0, 0, 0,              0, 0, 0,      1, 7, 0);
    op(0, 7, 7,  0, 0, 0,              0, 0, 0,      0, 0, 0);
    op(0, 7, 0,  1, 7, 32'hA5A5A5A5,   0, 0, 0,      0, 0, 0);
    op(0, 7, 7,  0, 0, 0,              0, 0, 0,      0, 0, 0);
    op(0, 3, 0,  0, 0, 0,              0, 0, 0,      1, 3, 0);
    op(0, 3, 0,  0, 0, 0,              0, 0, 0,      1, 3, 0);
    op(0, 3, 0,  1, 3, 32'h33,         0, 0, 0,      1, 3, 0);
    op(0, 3, 3,  0, 0, 0,              0, 0, 0,      0, 0, 0);
    op(0, 9, 9,  1, 9, 32'h11,         1, 9, 32'h22, 0, 0, 0);
    op(0, 9, 3,  0, 0, 0,              0, 0, 0,      0, 0, 0);
    op(0, 3, 0,  1, 3, 32'h44,         0, 0, 0,      1, 1, 0);
    op(0, 1, 0,  0, 0, 0,              0, 0, 0,      1, 2, 0);
    op(0, 2, 0,  0, 0, 0,              0, 0, 0,      1, 4, 0);
    op(0, 2, 6,  0, 0, 0,              1, 2, 32'h55, 1, 6, 1);
    op(0, 2, 6,  0, 0, 0,              0, 0, 0,      0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      stim_t s;
      s.rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < NRD; k++)
        s.ra[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      for (int j = 0; j < NWR; j++) begin
        s.we[j] = s.rst ? 1'b0 : ($urandom_range(0, 2) == 0);
        s.wa[j] = AW'($urandom_range(0, 7));
        s.wd[j] = $urandom;
      end
      s.ie  = ($urandom_range(0, 1) == 1);
      s.ird = ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      s.fl  = ($urandom_range(0, 29) == 0);
      apply(s);
    end
    drv_done = 1;
  end

  // Completion: drain outstanding predictions within a bounded number of cycles.
  initial begin
    wait (drv_done);
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain actual=%0d pending required=0 pending", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
